// File: rtl/vmc_arb_pkg.sv
// Shared types and constants for the Wishbone port arbiter of the memory controller.
// Build option: VMC_ARB_RR_EN selects round-robin instead of fixed-priority winner selection.
package vmc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_REFRESH
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // An acked beat closes the tenure unless the master announces more beats;
    // unknown cycle types are handled like classic cycles.
    function automatic logic cti_ends_tenure(input logic [2:0] cti);
        case (cti)
            CTI_CONST, CTI_INC:   cti_ends_tenure = 1'b0;
            CTI_CLASSIC, CTI_EOB: cti_ends_tenure = 1'b1;
            default:              cti_ends_tenure = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/vmc_arb_pick.sv
// Combinational winner selection among requesting ports.
// Build option: VMC_ARB_RR_EN rotates the search start to last+1; otherwise the
// lowest requesting index wins and the last input is ignored.
module vmc_arb_pick
    import vmc_arb_pkg::*;
#(
    parameter int NR_PORTS = 4,
    parameter int IDX_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic [NR_PORTS-1:0] req,
    input  logic [IDX_W-1:0]    last,
    output logic [NR_PORTS-1:0] win,
    output logic [IDX_W-1:0]    idx,
    output logic                any
);

`ifdef VMC_ARB_RR_EN
    int k;

    // Search every port once, starting just after the previous winner.
    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = 0; i < NR_PORTS; i++) begin
            k = (int'(last) + 1 + i) % NR_PORTS;
            if (!any && req[k]) begin
                any    = 1'b1;
                win[k] = 1'b1;
                idx    = IDX_W'(k);
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    // Lowest requesting index wins.
    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                win[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/vmc_wb_arbiter.sv
// Grants the SDRAM command path to one Wishbone master per tenure (classic
// cycle or whole burst) and slots auto-refresh in between tenures.
// Build option: VMC_ARB_RR_EN enables round-robin selection with a last-winner
// pointer; without it selection is fixed priority and no pointer exists.
module vmc_wb_arbiter
    import vmc_arb_pkg::*;
#(
    parameter int NR_PORTS = 4,
    parameter int IDX_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic [NR_PORTS-1:0]   cyc_i,
    input  logic [NR_PORTS-1:0]   stb_i,
    input  logic [3*NR_PORTS-1:0] cti_i,
    input  logic                  ack_i,
    input  logic                  refresh_req_i,
    input  logic                  refresh_done_i,
    output logic [NR_PORTS-1:0]   gnt_o,
    output logic [IDX_W-1:0]      gnt_idx_o,
    output logic                  gnt_vld_o,
    output logic                  refresh_gnt_o
);

    arb_state_t          state;
    logic [NR_PORTS-1:0] req;
    logic [NR_PORTS-1:0] pick_win;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [IDX_W-1:0]    last;
    logic                cur_cyc;
    logic [2:0]          cur_cti;
    logic                release_now;

    assign req = cyc_i & stb_i;

`ifndef VMC_ARB_RR_EN
    assign last = '0;
`endif

    vmc_arb_pick #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req  (req),
        .last (last),
        .win  (pick_win),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Route the granted port's cyc and cti using the registered one-hot grant.
    always_comb begin
        cur_cyc = 1'b0;
        cur_cti = CTI_CLASSIC;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (gnt_o[p]) begin
                cur_cyc = cyc_i[p];
                cur_cti = cti_i[3*p +: 3];
            end
        end
    end

    assign release_now = !cur_cyc || (ack_i && cti_ends_tenure(cur_cti));

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state         <= ST_IDLE;
            gnt_o         <= '0;
            gnt_idx_o     <= '0;
            gnt_vld_o     <= 1'b0;
            refresh_gnt_o <= 1'b0;
`ifdef VMC_ARB_RR_EN
            last          <= IDX_W'(NR_PORTS - 1);
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (refresh_req_i) begin
                        state         <= ST_REFRESH;
                        refresh_gnt_o <= 1'b1;
                    end else if (pick_any) begin
                        state     <= ST_GRANT;
                        gnt_o     <= pick_win;
                        gnt_idx_o <= pick_idx;
                        gnt_vld_o <= 1'b1;
`ifdef VMC_ARB_RR_EN
                        last      <= pick_idx;
`endif
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state     <= ST_IDLE;
                        gnt_o     <= '0;
                        gnt_idx_o <= '0;
                        gnt_vld_o <= 1'b0;
                    end
                end
                ST_REFRESH: begin
                    if (refresh_done_i) begin
                        state         <= ST_IDLE;
                        refresh_gnt_o <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    gnt_o         <= '0;
                    gnt_idx_o     <= '0;
                    gnt_vld_o     <= 1'b0;
                    refresh_gnt_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmc_wb_arbiter.sv
// Testbench for vmc_wb_arbiter: directed scenarios plus a randomized run
// against an owner-based reference model of the arbitration rules.
module tb_vmc_wb_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           wb_clk = 1'b0;
    logic           wb_rst;
    logic [N-1:0]   cyc_i;
    logic [N-1:0]   stb_i;
    logic [3*N-1:0] cti_i;
    logic           ack_i;
    logic           refresh_req_i;
    logic           refresh_done_i;
    logic [N-1:0]   gnt_o;
    logic [IW-1:0]  gnt_idx_o;
    logic           gnt_vld_o;
    logic           refresh_gnt_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the command path (0 nobody, 1 a port, 2 refresh)
    int m_mode = 0;
    int m_port = 0;
    int m_last = N - 1;

    vmc_wb_arbiter #(.NR_PORTS(N), .IDX_W(IW)) dut (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .cyc_i          (cyc_i),
        .stb_i          (stb_i),
        .cti_i          (cti_i),
        .ack_i          (ack_i),
        .refresh_req_i  (refresh_req_i),
        .refresh_done_i (refresh_done_i),
        .gnt_o          (gnt_o),
        .gnt_idx_o      (gnt_idx_o),
        .gnt_vld_o      (gnt_vld_o),
        .refresh_gnt_o  (refresh_gnt_o)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic model_edge();
        int w;
        int k;
        logic [2:0] c;
        w = -1;
        if (wb_rst) begin
            m_mode = 0;
            m_port = 0;
            m_last = N - 1;
        end else if (m_mode == 0) begin
            if (refresh_req_i) begin
                m_mode = 2;
            end else begin
                for (int i = 0; i < N; i++) begin
`ifdef VMC_ARB_RR_EN
                    k = (m_last + 1 + i) % N;
`else
                    k = i;
`endif
                    if (w < 0 && cyc_i[k] && stb_i[k]) w = k;
                end
                if (w >= 0) begin
                    m_mode = 1;
                    m_port = w;
                    m_last = w;
                end
            end
        end else if (m_mode == 1) begin
            c = cti_i[3*m_port +: 3];
            if (!cyc_i[m_port] || (ack_i && c != 3'b001 && c != 3'b010)) m_mode = 0;
        end else begin
            if (refresh_done_i) m_mode = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic on, input logic [2:0] t);
        cyc_i[p]         = on;
        stb_i[p]         = on;
        cti_i[3*p +: 3]  = t;
    endtask

    task automatic test_reset();
        wb_rst = 1'b1;
        tick();
        tick();
        checks++; if (gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt_o); end
        checks++; if (gnt_idx_o !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx_o); end
        checks++; if (gnt_vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", gnt_vld_o); end
        checks++; if (refresh_gnt_o !== 1'b0) begin failures++; $display("FAIL reset_rgnt got=%b exp=0", refresh_gnt_o); end
        wb_rst = 1'b0;
    endtask

    task automatic test_single();
        set_port(2, 1'b1, 3'b000);
        tick();
        checks++; if (gnt_o !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt_o); end
        checks++; if (gnt_idx_o !== 2'd2) begin failures++; $display("FAIL single_idx got=%0d exp=2", gnt_idx_o); end
        checks++; if (gnt_vld_o !== 1'b1) begin failures++; $display("FAIL single_vld got=%b exp=1", gnt_vld_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        set_port(2, 1'b0, 3'b000);
        checks++; if (gnt_vld_o !== 1'b0 || gnt_o !== 4'b0000) begin failures++; $display("FAIL single_release got=%b/%b exp=0/0000", gnt_vld_o, gnt_o); end
    endtask

    task automatic test_rr_fairness();
        int exp_seq[6];
        int n;
        logic [N-1:0] eg;
`ifdef VMC_ARB_RR_EN
        exp_seq = '{0, 1, 3, 0, 1, 3};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        set_port(0, 1'b1, 3'b000);
        set_port(1, 1'b1, 3'b000);
        set_port(3, 1'b1, 3'b000);
        for (int t = 0; t < 6; t++) begin
            n = 0;
            while (!gnt_vld_o && n < 8) begin
                tick();
                n++;
            end
            eg = '0;
            eg[exp_seq[t]] = 1'b1;
            checks++; if (n != 1) begin failures++; $display("FAIL rr_latency tenure=%0d got=%0d cycles exp=1", t, n); end
            checks++; if (gnt_idx_o !== IW'(exp_seq[t]) || gnt_o !== eg) begin failures++; $display("FAIL rr_order tenure=%0d got=%0d/%b exp=%0d/%b", t, gnt_idx_o, gnt_o, exp_seq[t], eg); end
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            checks++; if (gnt_vld_o !== 1'b0) begin failures++; $display("FAIL rr_bubble tenure=%0d got=%b exp=0", t, gnt_vld_o); end
        end
        cyc_i = '0;
        stb_i = '0;
        cti_i = '0;
        tick();
    endtask

    task automatic test_burst_hold();
        set_port(1, 1'b1, 3'b010);
        tick();
        checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== 2'd1) begin failures++; $display("FAIL burst_start got=%b/%0d exp=1/1", gnt_vld_o, gnt_idx_o); end
        set_port(0, 1'b1, 3'b000);
        for (int b = 0; b < 4; b++) begin
            cti_i[5:3] = (b < 3) ? 3'b010 : 3'b111;
            ack_i = 1'b1;
            tick();
            if (b < 3) begin
                checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== 2'd1) begin failures++; $display("FAIL burst_hold beat=%0d got=%b/%0d exp=1/1", b, gnt_vld_o, gnt_idx_o); end
            end else begin
                checks++; if (gnt_vld_o !== 1'b0) begin failures++; $display("FAIL burst_end got=%b exp=0", gnt_vld_o); end
            end
        end
        ack_i = 1'b0;
        set_port(1, 1'b0, 3'b000);
        tick();
        checks++; if (gnt_vld_o !== 1'b1 || gnt_o !== 4'b0001) begin failures++; $display("FAIL burst_next got=%b/%b exp=1/0001", gnt_vld_o, gnt_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        set_port(0, 1'b0, 3'b000);
    endtask

    task automatic test_refresh_boundary();
        set_port(0, 1'b1, 3'b010);
        tick();
        checks++; if (gnt_o !== 4'b0001) begin failures++; $display("FAIL rfb_start got=%b exp=0001", gnt_o); end
        set_port(1, 1'b1, 3'b000);
        ack_i = 1'b1;
        tick();
        refresh_req_i = 1'b1;
        tick();
        checks++; if (gnt_vld_o !== 1'b1 || refresh_gnt_o !== 1'b0) begin failures++; $display("FAIL rfb_no_preempt got=%b/%b exp=1/0", gnt_vld_o, refresh_gnt_o); end
        cti_i[2:0] = 3'b111;
        tick();
        checks++; if (gnt_vld_o !== 1'b0 || refresh_gnt_o !== 1'b0) begin failures++; $display("FAIL rfb_bubble got=%b/%b exp=0/0", gnt_vld_o, refresh_gnt_o); end
        ack_i = 1'b0;
        set_port(0, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (refresh_gnt_o !== 1'b1 || gnt_vld_o !== 1'b0) begin failures++; $display("FAIL rfb_refresh cyc=%0d got=%b/%b exp=1/0", i, refresh_gnt_o, gnt_vld_o); end
        end
        refresh_done_i = 1'b1;
        tick();
        refresh_done_i = 1'b0;
        refresh_req_i  = 1'b0;
        checks++; if (refresh_gnt_o !== 1'b0 || gnt_vld_o !== 1'b0) begin failures++; $display("FAIL rfb_done got=%b/%b exp=0/0", refresh_gnt_o, gnt_vld_o); end
        tick();
        checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== 2'd1) begin failures++; $display("FAIL rfb_after got=%b/%0d exp=1/1", gnt_vld_o, gnt_idx_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        set_port(1, 1'b0, 3'b000);
    endtask

    task automatic test_simultaneous_refresh();
        refresh_req_i = 1'b1;
        set_port(2, 1'b1, 3'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (refresh_gnt_o !== 1'b1 || gnt_vld_o !== 1'b0) begin failures++; $display("FAIL simul_refresh cyc=%0d got=%b/%b exp=1/0", i, refresh_gnt_o, gnt_vld_o); end
        end
        refresh_done_i = 1'b1;
        tick();
        refresh_done_i = 1'b0;
        refresh_req_i  = 1'b0;
        checks++; if (refresh_gnt_o !== 1'b0 || gnt_vld_o !== 1'b0) begin failures++; $display("FAIL simul_done got=%b/%b exp=0/0", refresh_gnt_o, gnt_vld_o); end
        tick();
        checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== 2'd2) begin failures++; $display("FAIL simul_port got=%b/%0d exp=1/2", gnt_vld_o, gnt_idx_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        set_port(2, 1'b0, 3'b000);
    endtask

    task automatic test_abort();
        set_port(3, 1'b1, 3'b010);
        tick();
        checks++; if (gnt_o !== 4'b1000) begin failures++; $display("FAIL abort_start got=%b exp=1000", gnt_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        checks++; if (gnt_vld_o !== 1'b1) begin failures++; $display("FAIL abort_mid got=%b exp=1", gnt_vld_o); end
        set_port(3, 1'b0, 3'b010);
        tick();
        checks++; if (gnt_vld_o !== 1'b0 || gnt_o !== 4'b0000) begin failures++; $display("FAIL abort_release got=%b/%b exp=0/0000", gnt_vld_o, gnt_o); end
    endtask

    task automatic test_reset_mid_burst();
        set_port(1, 1'b1, 3'b010);
        tick();
        ack_i = 1'b1;
        tick();
        checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== 2'd1) begin failures++; $display("FAIL rstmid_hold got=%b/%0d exp=1/1", gnt_vld_o, gnt_idx_o); end
        wb_rst = 1'b1;
        tick();
        checks++; if (gnt_o !== 4'b0000 || gnt_vld_o !== 1'b0 || refresh_gnt_o !== 1'b0 || gnt_idx_o !== 2'd0) begin failures++; $display("FAIL rstmid_clear got=%b/%b/%b/%0d exp=0000/0/0/0", gnt_o, gnt_vld_o, refresh_gnt_o, gnt_idx_o); end
        wb_rst = 1'b0;
        ack_i  = 1'b0;
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 3'b000);
        tick();
        checks++; if (gnt_o !== 4'b0001 || gnt_idx_o !== 2'd0) begin failures++; $display("FAIL rstmid_first got=%b/%0d exp=0001/0", gnt_o, gnt_idx_o); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        cyc_i = '0;
        stb_i = '0;
        cti_i = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        logic [2:0]   cti_set [5];
        cti_set = '{3'b000, 3'b001, 3'b010, 3'b111, 3'b011};
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(3) == 0) cyc_i[p] = ~cyc_i[p];
                stb_i[p] = cyc_i[p] & ($urandom_range(4) != 0);
                cti_i[3*p +: 3] = cti_set[$urandom_range(4)];
            end
            ack_i          = ($urandom_range(2) == 0);
            if ($urandom_range(15) == 0) refresh_req_i = 1'b1;
            else if (refresh_gnt_o && $urandom_range(3) == 0) refresh_req_i = 1'b0;
            refresh_done_i = ($urandom_range(3) == 0);
            wb_rst         = ($urandom_range(250) == 0);
            tick();
            eg = '0;
            if (m_mode == 1) eg[m_port] = 1'b1;
            checks++; if (gnt_vld_o !== (m_mode == 1)) begin failures++; $display("FAIL rand_vld cyc=%0d got=%b exp=%b", c, gnt_vld_o, (m_mode == 1)); end
            checks++; if (refresh_gnt_o !== (m_mode == 2)) begin failures++; $display("FAIL rand_rgnt cyc=%0d got=%b exp=%b", c, refresh_gnt_o, (m_mode == 2)); end
            checks++; if (gnt_o !== eg) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, gnt_o, eg); end
            if (m_mode == 1) begin
                checks++; if (gnt_idx_o !== IW'(m_port)) begin failures++; $display("FAIL rand_idx cyc=%0d got=%0d exp=%0d", c, gnt_idx_o, m_port); end
            end
            checks++; if (gnt_vld_o === 1'b1 && refresh_gnt_o === 1'b1) begin failures++; $display("FAIL rand_excl cyc=%0d got=both exp=at_most_one", c); end
        end
        wb_rst         = 1'b0;
        ack_i          = 1'b0;
        refresh_req_i  = 1'b0;
        refresh_done_i = 1'b0;
        cyc_i          = '0;
        stb_i          = '0;
    endtask

    initial begin
        wb_rst         = 1'b1;
        cyc_i          = '0;
        stb_i          = '0;
        cti_i          = '0;
        ack_i          = 1'b0;
        refresh_req_i  = 1'b0;
        refresh_done_i = 1'b0;
        @(posedge wb_clk);
        #1;
        test_reset();
        test_single();
        test_rr_fairness();
        test_burst_hold();
        test_refresh_boundary();
        test_simultaneous_refresh();
        test_abort();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vmc_wb_arbiter.md
# vmc_wb_arbiter

Arbitrates between `NR_PORTS` Wishbone masters sharing one clock domain of the versatile memory controller. It grants the single downstream SDRAM command path to one master at a time and holds the grant for a whole classic cycle or incrementing burst. It also inserts SDRAM auto-refresh slots between transactions. It sits between a clock domain's Wishbone port group and the controller's per-domain command FIFO.

## Interface
Parameters:
- `NR_PORTS`, 4: number of requesting Wishbone ports (1..8).
- `IDX_W`, `$clog2(NR_PORTS)` (min 1): width of the grant index.

Ports:
- `wb_clk`  in  1  domain clock; all logic is on its rising edge.
- `wb_rst`  in  1  reset; synchronous, active-high.
- `cyc_i`  in  NR_PORTS  per-port Wishbone `cyc`.
- `stb_i`  in  NR_PORTS  per-port Wishbone `stb`.
- `cti_i`  in  3*NR_PORTS  per-port `cti`; port k occupies bits [3k+2:3k].
- `ack_i`  in  1  downstream ack for the currently granted port.
- `refresh_req_i`  in  1  refresh timer request; level, held until serviced.
- `refresh_done_i`  in  1  one-cycle pulse; refresh command sequence complete.
- `gnt_o`  out  NR_PORTS  one-hot grant; all zero when no port is granted.
- `gnt_idx_o`  out  IDX_W  binary index of the granted port; valid while `gnt_vld_o`=1.
- `gnt_vld_o`  out  1  a port holds the grant.
- `refresh_gnt_o`  out  1  refresh owns the SDRAM command path.

## Operation
The arbiter is a state machine with three states: IDLE, GRANT and REFRESH.

- **IDLE**
  - If `refresh_req_i`=1, go to REFRESH. Refresh wins over all ports in the same cycle.
  - Otherwise, if any `req[k] = cyc_i[k] & stb_i[k]`, select a winner and go to GRANT.
  - Otherwise, stay in IDLE.
- **GRANT**
  - `gnt_o`, `gnt_idx_o` and `gnt_vld_o` are registered and stable for the whole tenure.
  - Release to IDLE on any of the following:
    - `cyc_i[g]`=0 (abort);
    - `ack_i`=1 with `cti_i[g]`=3'b000 (classic single);
    - `ack_i`=1 with `cti_i[g]`=3'b111 (end of burst).
  - `ack_i` with `cti_i[g]`=3'b001 or 3'b010 keeps the grant.
  - Any other `cti` value is treated as classic.
  - A pending `refresh_req_i` never preempts a grant.
- **REFRESH**
  - `refresh_gnt_o`=1 until `refresh_done_i`, then go to IDLE.
  - Port requests wait.
  - `refresh_done_i` outside REFRESH is ignored.
- **Winner selection:** done by a rotating priority search starting at `last+1` modulo `NR_PORTS`. `last` is updated to the winner on every grant.
- **Requester behaviour:** a requester that deasserts before it is selected loses nothing and is simply not granted.
- **Reset** (synchronous, any state, including mid-burst):
  - state goes to IDLE;
  - all outputs go to 0;
  - `last` goes to `NR_PORTS-1`, so port 0 wins first.

## Timing
- **Reset values:** `gnt_o`=0, `gnt_idx_o`=0, `gnt_vld_o`=0, `refresh_gnt_o`=0.
- **Grant latency:** a request sampled in IDLE at edge N gives outputs asserted after edge N+1. This is one cycle.
- **Release:** the releasing condition sampled at edge M gives `gnt_vld_o`=0 after edge M+1. The fabric sees a one-cycle IDLE bubble between consecutive tenures; back-to-back grants to different ports are therefore at least 2 cycles apart.
- **Refresh latency:** worst case is one maximal burst, plus 1 bubble cycle, plus 1 cycle.
- **Exclusivity:** `gnt_vld_o` and `refresh_gnt_o` are never both 1.
- **Single-port build:** with `NR_PORTS`=1, the search degenerates to `req[0]` and `gnt_idx_o` is constant 0.

## Configuration
- `VMC_ARB_RR_EN` defined: winner selection is round-robin as described in Operation, using the `last` pointer.
- `VMC_ARB_RR_EN` undefined:
  - fixed priority; the lowest requesting index wins;
  - the `last` register is not synthesised;
  - all other behaviour (states, timing, refresh) is identical.

## Structure
- Shared package `vmc_arb_pkg`:
  - state enum `{ST_IDLE, ST_GRANT, ST_REFRESH}`;
  - CTI constants `CTI_CLASSIC`=3'b000, `CTI_CONST`=3'b001, `CTI_INC`=3'b010, `CTI_EOB`=3'b111.
- One sub-module, `vmc_arb_pick`: a combinational rotating priority encoder.
  - Inputs: `req`, `last`.
  - Outputs: one-hot winner, index, any.
  - `VMC_ARB_RR_EN` selects rotation versus fixed priority inside it.

## Test plan
- **Single request.** Reset, then port 2 raises `cyc`/`stb` with `cti`=000. Expect `gnt_o`=4'b0100 and `gnt_idx_o`=2 one cycle later. On `ack_i`, the grant drops the next cycle.
- **Round-robin fairness.** Ports 0, 1 and 3 hold requests continuously with classic cycles acked immediately. Expect grant order 0, 1, 3, 0, 1, 3, with one IDLE cycle between tenures. Without `VMC_ARB_RR_EN`, expect port 0 every tenure.
- **Burst hold.** Port 1 issues a 4-beat burst with `cti` = 010, 010, 010, 111 while port 0 requests. Port 1 keeps the grant through all 4 acks, then port 0 is granted 2 cycles after the final ack.
- **Refresh at boundary.** `refresh_req_i` rises mid-burst of port 0. `refresh_gnt_o` rises only after the EOB ack plus the bubble, and drops the cycle after the `refresh_done_i` pulse. The pending port 1 is granted afterwards.
- **Simultaneous refresh and request in IDLE.** Both arrive in the same cycle. Refresh is granted first; port requests wait; `gnt_vld_o` stays 0 throughout.
- **Abort and reset.** Port 3 drops `cyc` mid-burst, which releases the grant without an ack. Separately, asserting `wb_rst` during GRANT clears all outputs at the next edge, and the first grant after reset goes to port 0.
